// File: rtl/spi_slave_regfile.sv
// SPI responder with an internal DEPTH x 8-bit register file.
// Frames: op bit, 8 address bits LSB first, and for writes 8 data bits LSB first.
module spi_slave_regfile #(
    parameter int DEPTH = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic cs,
    input  logic mosi,
    output logic ready,
    output logic miso,
    output logic op_done,
    output logic err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WDATA,
        S_COMMIT,
        S_RDLOAD,
        S_RDSHIFT,
        S_DONE,
        S_WAIT_CS
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [2:0]  r_cnt;
    logic [2:0]  w_cnt_nxt;
    logic        r_op;
    logic        w_op_nxt;
    logic [7:0]  r_addr;
    logic [7:0]  w_addr_nxt;
    logic [7:0]  r_shift;
    logic [7:0]  w_shift_nxt;
    logic        r_pend_err;
    logic        w_pend_err_nxt;
    logic        r_ready;
    logic        w_ready_nxt;
    logic        r_miso;
    logic        w_miso_nxt;
    logic        r_op_done;
    logic        w_op_done_nxt;
    logic        r_err;
    logic        w_err_nxt;
    logic        w_mem_we;
    logic        w_in_range;
    logic [7:0]  w_rdata;
    logic [7:0]  r_mem [DEPTH];

    // Full 8-bit compare: addresses at or above DEPTH never alias onto storage.
    assign w_in_range = ({1'b0, r_addr} < 9'(DEPTH));
    assign w_rdata    = w_in_range ? r_mem[r_addr[AW-1:0]] : 8'h00;

    assign ready   = r_ready;
    assign miso    = r_miso;
    assign op_done = r_op_done;
    assign err     = r_err;

    // Next-state and next-output logic; pulses default low every cycle.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_op_nxt       = r_op;
        w_addr_nxt     = r_addr;
        w_shift_nxt    = r_shift;
        w_pend_err_nxt = r_pend_err;
        w_ready_nxt    = 1'b0;
        w_miso_nxt     = 1'b0;
        w_op_done_nxt  = 1'b0;
        w_err_nxt      = 1'b0;
        w_mem_we       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!cs) begin
                    w_op_nxt       = mosi;
                    w_cnt_nxt      = 3'd0;
                    w_pend_err_nxt = 1'b0;
                    w_state_nxt    = S_ADDR;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_ADDR: begin
                if (cs) begin
                    w_state_nxt   = S_IDLE;
                    w_op_done_nxt = 1'b1;
                    w_err_nxt     = 1'b1;
                end else begin
                    w_addr_nxt = {mosi, r_addr[7:1]};
                    w_cnt_nxt  = r_cnt + 3'd1;
                    if (r_cnt == 3'd7) begin
                        w_cnt_nxt = 3'd0;
                        if (r_op) begin
                            w_state_nxt = S_WDATA;
                        end else begin
                            w_state_nxt = S_RDLOAD;
                            w_ready_nxt = 1'b1;
                        end
                    end else begin
                        w_state_nxt = S_ADDR;
                    end
                end
            end
            S_WDATA: begin
                if (cs) begin
                    w_state_nxt   = S_IDLE;
                    w_op_done_nxt = 1'b1;
                    w_err_nxt     = 1'b1;
                end else begin
                    w_shift_nxt = {mosi, r_shift[7:1]};
                    w_cnt_nxt   = r_cnt + 3'd1;
                    if (r_cnt == 3'd7) begin
                        w_state_nxt   = S_COMMIT;
                        w_op_done_nxt = 1'b1;
                        w_err_nxt     = ~w_in_range;
                    end else begin
                        w_state_nxt = S_WDATA;
                    end
                end
            end
            S_COMMIT: begin
                w_mem_we    = w_in_range;
                w_state_nxt = S_WAIT_CS;
            end
            S_RDLOAD: begin
                w_miso_nxt     = w_rdata[0];
                w_shift_nxt    = {1'b0, w_rdata[7:1]};
                w_pend_err_nxt = ~w_in_range;
                w_cnt_nxt      = 3'd0;
                w_state_nxt    = S_RDSHIFT;
            end
            S_RDSHIFT: begin
                if (cs) begin
                    w_state_nxt   = S_IDLE;
                    w_op_done_nxt = 1'b1;
                    w_err_nxt     = 1'b1;
                end else if (r_cnt == 3'd7) begin
                    w_state_nxt   = S_DONE;
                    w_op_done_nxt = 1'b1;
                    w_err_nxt     = r_pend_err;
                end else begin
                    w_miso_nxt  = r_shift[0];
                    w_shift_nxt = {1'b0, r_shift[7:1]};
                    w_cnt_nxt   = r_cnt + 3'd1;
                    w_state_nxt = S_RDSHIFT;
                end
            end
            S_DONE: begin
                w_state_nxt = S_WAIT_CS;
            end
            S_WAIT_CS: begin
                if (cs) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_WAIT_CS;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State, datapath and registered output pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= 3'd0;
            r_op       <= 1'b0;
            r_addr     <= 8'h00;
            r_shift    <= 8'h00;
            r_pend_err <= 1'b0;
            r_ready    <= 1'b0;
            r_miso     <= 1'b0;
            r_op_done  <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_op       <= w_op_nxt;
            r_addr     <= w_addr_nxt;
            r_shift    <= w_shift_nxt;
            r_pend_err <= w_pend_err_nxt;
            r_ready    <= w_ready_nxt;
            r_miso     <= w_miso_nxt;
            r_op_done  <= w_op_done_nxt;
            r_err      <= w_err_nxt;
        end
    end

    // Register file storage, cleared by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 8'h00;
            end
        end else if (w_mem_we) begin
            r_mem[r_addr[AW-1:0]] <= r_shift;
        end else begin
            r_mem <= r_mem;
        end
    end

endmodule
